// File: rtl/axis_chinsert_pfb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_chinsert_pfb
// Brief    : Channel inserter for the synthesis PFB. Buffers sparse lane
//            words tagged with their TDM transaction index and rebuilds a
//            continuous, frame-aligned TDM stream of NT = NCH/L slots per
//            frame. Slots without a matching word are zero-filled.
// Options  : CHINSERT_DROPCNT_EN - when defined, drop_cnt counts discarded
//            input beats (saturating). Otherwise drop_cnt is tied to zero.
// Notes    : NT must be a power of 2 in 2..32. FIFO_DEPTH must be a power
//            of 2, at least 4.
// Revision : 1.0 - initial release
// ============================================================================
module axis_chinsert_pfb #(
  parameter int B          = 16,
  parameter int NCH        = 64,
  parameter int L          = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [B*L-1:0]     s_axis_tdata,
  input  logic [15:0]        s_axis_tuser,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic [B*L-1:0]     m_axis_tdata,
  input  logic               START_REG,
  input  logic [31:0]        PUNCT_REG,
  output logic [15:0]        drop_cnt
);

  localparam int NT = NCH / L;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = B * L;
  localparam int EW = IW + W;

  localparam logic [IW-1:0] LAST_SLOT = IW'(NT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   cnt_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic [W-1:0]    tdata_q;

  // Buffer storage: each entry is {slot index, lane word}
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            full_q;
  logic            push_q;

  logic            running;
  logic            in_fire;
  logic            keep_ok;
  logic            push;
  logic            pop;
  logic            head_ready;
  logic [IW-1:0]   in_idx;
  logic [EW-1:0]   head;

  assign running       = (state_q != IDLE);
  assign s_axis_tready = running && !full_q;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // Only in-range, enabled slots are buffered; everything else is dropped.
  assign in_idx  = s_axis_tuser[IW-1:0];
  assign keep_ok = (s_axis_tuser[15:IW] == '0) && PUNCT_REG[in_idx];
  assign push    = in_fire && keep_ok;

  // An entry written on the previous edge is not yet poppable; this gives
  // the head compare a full cycle after the write.
  assign head       = mem_q[rd_ptr_q];
  assign head_ready = (count_q > {{AW{1'b0}}, push_q});
  assign pop        = running && head_ready && (head[EW-1:W] == cnt_q);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer data write port
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_idx, s_axis_tdata};
    end
  end

  // Buffer pointers, occupancy and full flag; flushed whenever idle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      push_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
      push_q  <= push;
    end
  end

  // Run/stop sequencing, slot counter and registered output beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          tdata_q  <= '0;
          if (START_REG) begin
            state_q <= RUN;
          end
        end
        RUN, STOP: begin
          tvalid_q <= 1'b1;
          tlast_q  <= (cnt_q == LAST_SLOT);
          tdata_q  <= pop ? head[W-1:0] : '0;
          if (cnt_q == LAST_SLOT) begin
            cnt_q <= '0;
            // A stop request only takes effect on a frame boundary
            if (!START_REG || (state_q == STOP)) begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if ((state_q == RUN) && !START_REG) begin
              state_q <= STOP;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;

`ifdef CHINSERT_DROPCNT_EN
  logic [15:0] drop_q;
  logic        discard;

  assign discard = in_fire && !keep_ok;

  // Saturating count of discarded beats, cleared while idle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else if (state_q == IDLE) begin
      drop_q <= '0;
    end else if (discard && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_chinsert_pfb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_chinsert_pfb
// Brief    : Self-checking bench for axis_chinsert_pfb (NCH=64, L=8, NT=8).
//            A table of input beats plus hand-written sequences; words that
//            must appear are queued and matched against output in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_chinsert_pfb;

  localparam int B  = 16;
  localparam int NCH = 64;
  localparam int L  = 8;
  localparam int NT = 8;
  localparam int FD = 16;
  localparam int W  = B * L;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic [15:0]   s_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [W-1:0]  m_axis_tdata;
  logic          START_REG;
  logic [31:0]   PUNCT_REG;
  logic [15:0]   drop_cnt;

  always #5 aclk = ~aclk;

  axis_chinsert_pfb #(.B(B), .NCH(NCH), .L(L), .FIFO_DEPTH(FD)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .START_REG     (START_REG),
    .PUNCT_REG     (PUNCT_REG),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    logic [2:0]   slot;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic [31:0]  punct;
    logic [15:0]  tuser;
    logic [W-1:0] data;
    bit           keep;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] obs [64];
  int           nbeat = 0;
  int           mslot = 0;
  int           last_run_len = 0;
  logic         prev_valid = 1'b0;
  bit           mon_en = 1'b0;
  vec_t         vt [16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: slot/tlast tracking, frame integrity and scoreboard match
  always @(negedge aclk) begin
    if (mon_en) begin
      if (m_axis_tvalid) begin
        chk("tlast", W'(m_axis_tlast), W'(mslot == NT - 1));
        if (m_axis_tdata != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected no word (slot %0d)", m_axis_tdata, mslot);
          end else begin
            mon_e = sb.pop_front();
            chk("sb_data", m_axis_tdata, mon_e.data);
            chk("sb_slot", W'(mslot), W'(mon_e.slot));
          end
        end
        if (nbeat < 64) obs[nbeat] = m_axis_tdata;
        nbeat++;
        mslot = (mslot + 1) % NT;
      end else begin
        if (prev_valid) begin
          last_run_len = nbeat;
          chk("frame_whole", W'(mslot), W'(0));
        end
        mslot = 0;
        nbeat = 0;
      end
      prev_valid = m_axis_tvalid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_run();
    START_REG = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [15:0] u, input logic [W-1:0] d, input bit keep);
    int   w = 0;
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = u;
    s_axis_tdata  = d;
    @(negedge aclk);
    while (!s_axis_tready && w < 300) begin
      @(negedge aclk);
      w++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tready got 0 expected 1 (tuser %0h)", u);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    if (keep) begin
      e.slot = u[2:0];
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic wait_beats(input int n);
    int w = 0;
    while (nbeat < n && w < 200) begin
      @(negedge aclk);
      w++;
    end
    chk("wait_beats", W'(nbeat >= n), W'(1));
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_sb_empty(input int maxc);
    int w = 0;
    while (sb.size() != 0 && w < maxc) begin
      @(negedge aclk);
      w++;
    end
    chk("sb_drained", W'(sb.size()), W'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic stop_run();
    int w = 0;
    START_REG = 1'b0;
    @(negedge aclk);
    while ((m_axis_tvalid || s_axis_tready) && w < 40) begin
      @(negedge aclk);
      w++;
    end
    chk("reach_idle", W'(m_axis_tvalid || s_axis_tready), W'(0));
    tick(2);
  endtask

  // Global time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int   ndrop;
    int   acc;
    int   emitted;
    bit   got_full;
    int   w;
    exp_t e;
    logic [W-1:0] sparse_exp [8];

    // Input vector table: {PUNCT, tuser, data, expected to be emitted}
    for (int i = 0; i < 8; i++) vt[i] = '{32'hFF, 16'(i), W'(16'h10 + i), 1'b1};
    vt[8]  = '{32'h01,  16'h0000, W'(16'h20), 1'b1};
    vt[9]  = '{32'h01,  16'h0003, W'(16'h23), 1'b0};
    vt[10] = '{32'h01,  16'h0100, W'(16'h24), 1'b0};
    vt[11] = '{32'h01,  16'h0008, W'(16'h25), 1'b0};
    vt[12] = '{32'h24,  16'h0002, W'(16'h0A), 1'b1};
    vt[13] = '{32'h24,  16'h0005, W'(16'h0B), 1'b1};
    vt[14] = '{32'h24,  16'h0000, W'(16'h26), 1'b0};
    vt[15] = '{32'h100, 16'h0000, W'(16'h27), 1'b0};

    sparse_exp = '{W'(0), W'(0), W'(16'hA), W'(0), W'(0), W'(16'hB), W'(0), W'(0)};

    // Reset and idle
    START_REG     = 1'b0;
    PUNCT_REG     = 32'h0;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 16'h0;
    s_axis_tdata  = '1;
    mon_en        = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_tready", W'(s_axis_tready), W'(0));
    chk("rst_tvalid", W'(m_axis_tvalid), W'(0));
    chk("rst_tlast",  W'(m_axis_tlast), W'(0));
    chk("rst_tdata",  m_axis_tdata, W'(0));
    chk("rst_drop",   W'(drop_cnt), W'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick(3);
    @(negedge aclk);
    chk("idle_tready", W'(s_axis_tready), W'(0));
    chk("idle_tvalid", W'(m_axis_tvalid), W'(0));
    chk("idle_tdata",  m_axis_tdata, W'(0));
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;

    // Full mask, continuous in-order feed: first frame empty, then data
    PUNCT_REG = 32'hFF;
    start_run();
    for (int i = 0; i < 32; i++) send(16'(i % 8), W'(16'h10 + (i % 8)), 1'b1);
    wait_beats(40);
    for (int b = 0; b < 8; b++) chk("full_first_frame", obs[b], W'(0));
    for (int b = 8; b < 40; b++) chk("full_data", obs[b], W'(16'h10 + (b % 8)));
    wait_sb_empty(50);
    stop_run();

    // Table-driven filter vectors
    ndrop = 0;
    start_run();
    for (int i = 0; i < 16; i++) begin
      PUNCT_REG = vt[i].punct;
      send(vt[i].tuser, vt[i].data, vt[i].keep);
      if (!vt[i].keep) ndrop++;
    end
    PUNCT_REG = 32'h0;
    wait_sb_empty(100);
`ifdef CHINSERT_DROPCNT_EN
    chk("drop_cnt", W'(drop_cnt), W'(ndrop));
`else
    chk("drop_cnt", W'(drop_cnt), W'(0));
`endif
    stop_run();
    chk("drop_clr", W'(drop_cnt), W'(0));

    // Sparse insert: exact frame 0,0,A,0,0,B,0,0
    PUNCT_REG = 32'h24;
    start_run();
    chk("first_cycle_tvalid", W'(m_axis_tvalid), W'(0));
    send(16'd2, W'(16'hA), 1'b1);
    send(16'd5, W'(16'hB), 1'b1);
    wait_beats(8);
    for (int b = 0; b < 8; b++) chk("sparse_frame", obs[b], sparse_exp[b]);
    stop_run();

    // Out-of-order: idx1 pushed at slot 3 waits for next slot 1; idx0 behind it
    PUNCT_REG = 32'hFF;
    start_run();
    tick(3);
    send(16'd1, W'(16'h51), 1'b1);
    send(16'd0, W'(16'h50), 1'b1);
    wait_beats(17);
    chk("ooo_slot1_frame0", obs[1], W'(0));
    chk("ooo_idx1_at_9", obs[9], W'(16'h51));
    chk("ooo_slot0_frame1", obs[8], W'(0));
    chk("ooo_idx0_at_16", obs[16], W'(16'h50));
    stop_run();

    // Backpressure: every word tagged slot 7
    PUNCT_REG = 32'h80;
    start_run();
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 16'd7;
    s_axis_tdata  = W'(16'h700);
    acc = 0;
    emitted = 0;
    got_full = 1'b0;
    w = 0;
    while (!got_full && w < 100) begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tdata != '0) emitted++;
      if (!s_axis_tready) begin
        got_full = 1'b1;
      end else begin
        @(posedge aclk);
        e.slot = 3'd7;
        e.data = s_axis_tdata;
        sb.push_back(e);
        acc++;
        #1;
        s_axis_tdata = W'(16'h700 + acc);
      end
      w++;
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    chk("bp_full_seen", W'(got_full), W'(1));
    chk("bp_occupancy", W'(acc - emitted), W'(FD));
    wait_sb_empty(250);
    chk("bp_tready_back", W'(s_axis_tready), W'(1));
    stop_run();

    // Stop mid-frame at slot 4: frame completes, buffered word is flushed
    PUNCT_REG = 32'hFF;
    start_run();
    tick(1);
    send(16'd0, W'(16'h99), 1'b0);
    tick(2);
    START_REG = 1'b0;
    w = 0;
    @(negedge aclk);
    while ((m_axis_tvalid || s_axis_tready) && w < 40) begin
      @(negedge aclk);
      w++;
    end
    tick(2);
    chk("stop_run_len", W'(last_run_len), W'(8));
    chk("stop_idle_tready", W'(s_axis_tready), W'(0));
    chk("stop_idle_tvalid", W'(m_axis_tvalid), W'(0));
    start_run();
    wait_beats(9);
    chk("flushed_slot0", obs[0], W'(0));
    chk("flushed_slot8", obs[8], W'(0));
    stop_run();

    // Asynchronous reset mid-frame
    mon_en = 1'b0;
    PUNCT_REG = 32'hFF;
    start_run();
    send(16'd3, W'(16'h33), 1'b0);
    tick(3);
    chk("pre_reset_data", m_axis_tdata, W'(16'h33));
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", W'(m_axis_tvalid), W'(0));
    chk("async_rst_tdata",  m_axis_tdata, W'(0));
    chk("async_rst_tready", W'(s_axis_tready), W'(0));
    chk("async_rst_tlast",  W'(m_axis_tlast), W'(0));
    START_REG = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick(2);
    chk("post_rst_tvalid", W'(m_axis_tvalid), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_chinsert_pfb.md
# axis_chinsert_pfb

Channel inserter for the synthesis side of the polyphase filter bank. Accepts a sparse stream of lane words tagged with their TDM transaction index and rebuilds a continuous, frame-aligned TDM stream (NCH/L transactions per frame, tlast on the last one) for the synthesis PFB. Unused slots are zero-filled. It is the transmit-side counterpart of the analysis-side channel selector: that block strips transactions and tags them, and this block re-inserts them.

## Interface
Parameters:
- B, 16: bits per complex word.
- NCH, 64: number of channels.
- L, 8: number of lanes. NT = NCH/L transactions per frame. NT must be a power of 2, at most 32.
- FIFO_DEPTH, 16: input buffer depth in words. Must be a power of 2, at least 4.

Ports:
- aclk  in  1  Single clock.
- aresetn  in  1  Reset, asynchronous, active-low.
- s_axis_tvalid  in  1  Input word valid.
- s_axis_tready  out  1  Input ready.
- s_axis_tdata  in  B*L  Input lane word.
- s_axis_tuser  in  16  Target transaction index. Only bits [log2(NT)-1:0] are significant; upper bits must be 0.
- m_axis_tvalid  out  1  Output valid. No tready; the sink consumes every cycle.
- m_axis_tlast  out  1  High on transaction NT-1 of each frame.
- m_axis_tdata  out  B*L  Output lane word, or zero for an empty slot.
- START_REG  in  1  Run enable, quasi-static, synchronous to aclk.
- PUNCT_REG  in  32  Slot enable mask. Bit i enables transaction i. Bits at NT and above are ignored.
- drop_cnt  out  16  Dropped-input counter (see Configuration).

## Operation
- The input FIFO has FIFO_DEPTH entries, each holding {tuser index, tdata}.
- Input filter: an accepted beat is written to the FIFO only if its index is below NT, its upper tuser bits are 0, and its PUNCT_REG bit is 1. Any other accepted beat is discarded.
- s_axis_tready = (state != IDLE) && !full. The full flag is registered from the occupancy count.
- Slot counter cnt runs over 0..NT-1. It increments every cycle in RUN and STOP and wraps from NT-1 to 0.
- Per cycle in RUN/STOP:
  - If the FIFO is non-empty and the head index equals cnt, pop the head and register its data to the output.
  - Otherwise register zeros to the output.
  - A head whose index does not match waits, so it is emitted within at most NT cycles.
- Order is preserved. A word is never emitted in a slot other than its tagged one.
- States:
  - IDLE: cnt=0, outputs 0, FIFO flushed (pointers and count cleared). Go to RUN when START_REG=1.
  - RUN: streaming. When START_REG=0, go to STOP if cnt != NT-1; otherwise go to IDLE after the tlast cycle.
  - STOP: keep streaming (tready stays as in RUN) until the beat with cnt=NT-1 has been emitted, then go to IDLE. Frames are never truncated.
- A simultaneous push and pop in the same cycle leaves the occupancy count unchanged.

## Timing
- Reset (async assert): state=IDLE, cnt=0, FIFO empty, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, drop_cnt=0.
- The output is fully registered. m_axis_tvalid rises 1 cycle after the first RUN cycle, and that first output beat is slot 0.
- m_axis_tlast = registered (cnt==NT-1).
- Minimum latency: a beat accepted at edge k is at the FIFO head after edge k+1. If cnt==index during cycle k+1, the beat is on m_axis after edge k+2.
- Throughput: up to one word per cycle when the tags are in consecutive slot order.
- Reset mid-frame: everything returns immediately to reset values. No partial-frame completion.
- Changes to PUNCT_REG affect only the input filter. Words already buffered are still emitted.

## Configuration
- CHINSERT_DROPCNT_EN defined: drop_cnt increments by 1 on each discarded accepted beat, saturates at 0xFFFF, and clears in IDLE.
- Not defined: no counter logic is built and drop_cnt is tied to 0. The filter and discard behaviour are identical in both builds.

## Test plan
All scenarios use NCH=64, L=8, so NT=8.
- Reset and idle: START_REG=0, drive s_axis_tvalid=1 -> tready=0, m_axis_tvalid=0, all outputs 0.
- Full mask: PUNCT=0xFF, START=1, feed indices 0..7 with data 0x10..0x17, repeating -> continuous frames with data 0x10..0x17, tlast only on slot 7, no zero slots after the first fill.
- Sparse insert: PUNCT=0x24, feed idx2=0xA, idx5=0xB once -> frame output 0,0,0xA,0,0,0xB,0,0 with tlast on the 8th beat.
- Out-of-order wait: cnt at 3, push idx1 -> emitted at the next slot 1, 6 cycles later. Idx1 followed by idx0 -> idx0 appears in the following frame.
- Filter and count (macro on): PUNCT=0x01, push idx0, idx3, tuser=0x0100 -> only idx0 emitted and drop_cnt=2. With the macro off, drop_cnt=0.
- Backpressure and stop: stall the matching slot (tags all idx7) with FIFO_DEPTH=16 -> tready drops after 16 words. Deassert START mid-frame at cnt=4 -> beats continue through tlast, then tvalid=0 and the FIFO is flushed.
